// File: rtl/training_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : training_sequencer
// Description : Per-epoch weight-update sequencer (Manhattan / Adam) that
//               adapts eta, tracks best error and sweeps weight memory.
// Revision    : 1.0 - initial release
// ============================================================================
module training_sequencer #(
    parameter int BIT_WIDTH      = 32,
    parameter int EXTRA_BIT      = 2,
    parameter int NUMBER_WEIGHTS = 2,
    parameter int NUMBER_NEURONS = 1,
    parameter int MAX_EPOCHS     = 1024,
    parameter logic [BIT_WIDTH+EXTRA_BIT-1:0] ETA_INIT = {2'b01, 32'h3DCCCCCD},
    parameter logic [7:0] ETA_MIN_EXP = 8'd100,
    parameter logic [7:0] ETA_MAX_EXP = 8'd126
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   training_mode,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]         squared_error,
    output logic                                   mem_rd_en,
    output logic [((NUMBER_WEIGHTS*NUMBER_NEURONS) > 1 ?
                   $clog2(NUMBER_WEIGHTS*NUMBER_NEURONS) : 1)-1:0] mem_addr,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]         old_weight,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]         delta_weight,
    output logic                                   upd_req,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]         upd_a,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]         upd_b,
    output logic                                   upd_adam,
    input  logic                                   upd_done,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]         upd_result,
    output logic                                   write_en,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]         memory_updated_weight,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]         eta,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]         best_error,
    output logic                                   busy,
    output logic                                   epoch_done,
    output logic                                   training_done
);

    localparam int W       = BIT_WIDTH + EXTRA_BIT;
    localparam int N       = NUMBER_WEIGHTS * NUMBER_NEURONS;
    localparam int AW      = (N > 1) ? $clog2(N) : 1;
    localparam int EW      = $clog2(MAX_EPOCHS) + 1;
    localparam int SGN     = BIT_WIDTH - 1;
    localparam int EXP_MSB = BIT_WIDTH - 2;
    localparam int EXP_LSB = BIT_WIDTH - 9;
    localparam logic [W-1:0]  c_BEST_INIT  = W'({2'b01, 32'h7F7FFFFF});
    localparam logic [AW-1:0] c_LAST_ADDR  = AW'(N - 1);
    localparam logic [EW-1:0] c_LAST_EPOCH = EW'(MAX_EPOCHS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EVAL    = 3'd1,
        S_RD      = 3'd2,
        S_WAIT_RD = 3'd3,
        S_REQ     = 3'd4,
        S_WR      = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic [W-1:0]  r_error, r_eta, r_best, r_upd_a, r_upd_b, r_wdata;
    logic          r_mode, r_upd_adam, r_busy, r_epoch_done, r_done;
    logic [AW-1:0] r_addr;
    logic [EW-1:0] r_epoch;

    logic          w_err_zero, w_best_zero, w_improved, w_last_epoch;
    logic          w_delta_zero, w_last_addr;
    logic [W-1:0]  w_err_cmp, w_best_cmp, w_step;
    logic [7:0]    w_exp, w_exp_up, w_exp_dn;

    // Exception prefix 00 encodes zero regardless of the payload bits.
    assign w_err_zero   = (r_error[W-1 -: EXTRA_BIT] == '0);
    assign w_best_zero  = (r_best[W-1 -: EXTRA_BIT] == '0);
    assign w_err_cmp    = w_err_zero  ? '0 : r_error;
    assign w_best_cmp   = w_best_zero ? '0 : r_best;
    assign w_improved   = (w_err_cmp < w_best_cmp);
    assign w_last_epoch = (r_epoch == c_LAST_EPOCH);
    assign w_delta_zero = (delta_weight[W-1 -: EXTRA_BIT] == '0);
    assign w_last_addr  = (r_addr == c_LAST_ADDR);

    assign w_exp    = r_eta[EXP_MSB:EXP_LSB];
    assign w_exp_up = (w_exp >= ETA_MAX_EXP) ? ETA_MAX_EXP : w_exp + 8'd1;
    assign w_exp_dn = (w_exp <= ETA_MIN_EXP) ? ETA_MIN_EXP : w_exp - 8'd1;

    // Step opposes the gradient sign; Manhattan takes magnitude from eta.
    assign w_step = r_mode ? {2'b01, ~delta_weight[SGN], r_eta[SGN-1:0]}
                           : {delta_weight[W-1 -: EXTRA_BIT], ~delta_weight[SGN],
                              delta_weight[SGN-1:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start && !r_done) w_next = S_EVAL;
            S_EVAL:    w_next = (w_err_zero || w_last_epoch) ? S_IDLE : S_RD;
            S_RD:      w_next = S_WAIT_RD;
            S_WAIT_RD: w_next = w_delta_zero ? S_WR : S_REQ;
            S_REQ:     if (upd_done) w_next = S_WR;
            S_WR:      w_next = w_last_addr ? S_IDLE : S_RD;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error      <= '0;
            r_mode       <= 1'b0;
            r_eta        <= ETA_INIT;
            r_best       <= c_BEST_INIT;
            r_upd_a      <= '0;
            r_upd_b      <= '0;
            r_upd_adam   <= 1'b0;
            r_wdata      <= '0;
            r_addr       <= '0;
            r_epoch      <= '0;
            r_busy       <= 1'b0;
            r_epoch_done <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_epoch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !r_done) begin
                        r_error <= squared_error;
                        r_mode  <= training_mode;
                    end
                end
                S_EVAL: begin
                    if (w_err_zero || w_last_epoch) begin
                        r_done <= 1'b1;
                    end else begin
                        if (w_improved) r_best <= r_error;
                        if (r_mode) r_eta[EXP_MSB:EXP_LSB] <= w_improved ? w_exp_up : w_exp_dn;
                        r_addr <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_WAIT_RD: begin
                    r_upd_a    <= old_weight;
                    r_upd_b    <= w_step;
                    r_upd_adam <= ~r_mode;
                    if (w_delta_zero) r_wdata <= old_weight;
                end
                S_REQ: begin
                    if (upd_done) r_wdata <= upd_result;
                end
                S_WR: begin
                    if (w_last_addr) begin
                        r_busy       <= 1'b0;
                        r_epoch_done <= 1'b1;
                        r_epoch      <= r_epoch + 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en             = (r_state == S_RD);
    assign upd_req               = (r_state == S_REQ);
    assign write_en              = (r_state == S_WR);
    assign mem_addr              = r_addr;
    assign upd_a                 = r_upd_a;
    assign upd_b                 = r_upd_b;
    assign upd_adam              = r_upd_adam;
    assign memory_updated_weight = r_wdata;
    assign eta                   = r_eta;
    assign best_error            = r_best;
    assign busy                  = r_busy;
    assign epoch_done            = r_epoch_done;
    assign training_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_training_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_training_sequencer
// Description : Scoreboard bench for training_sequencer with memory and FP
//               adder models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_training_sequencer;

    localparam int W = 34;
    localparam int N = 2;
    localparam logic [W-1:0] c_ETA_123  = {2'b01, 32'h3DCCCCCD};
    localparam logic [W-1:0] c_ETA_124  = {2'b01, 32'h3E4CCCCD};
    localparam logic [W-1:0] c_BEST_RST = {2'b01, 32'h7F7FFFFF};
    localparam logic [W-1:0] c_ONE      = {2'b01, 32'h3F800000};
    localparam logic [W-1:0] c_HALF     = {2'b01, 32'h3F000000};
    localparam logic [W-1:0] c_TWO      = {2'b01, 32'h40000000};
    localparam logic [W-1:0] c_DPOS     = {2'b01, 32'h3DB851EC};
    localparam logic [W-1:0] c_DNEG     = {2'b01, 32'hBDB851EC};
    localparam logic [W-1:0] c_ZERO     = {2'b00, 32'h00000000};

    logic          clk = 1'b0;
    logic          rst, start, training_mode;
    logic [W-1:0]  squared_error;
    logic          mem_rd_en;
    logic [0:0]    mem_addr;
    logic [W-1:0]  old_weight = '0, delta_weight = '0;
    logic          upd_req, upd_adam;
    logic [W-1:0]  upd_a, upd_b;
    logic          upd_done = 1'b0;
    logic [W-1:0]  upd_result = '0;
    logic          write_en;
    logic [W-1:0]  memory_updated_weight, eta, best_error;
    logic          busy, epoch_done, training_done;

    training_sequencer #(
        .MAX_EPOCHS  (4),
        .ETA_MIN_EXP (8'd123),
        .ETA_MAX_EXP (8'd124)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .training_mode         (training_mode),
        .squared_error         (squared_error),
        .mem_rd_en             (mem_rd_en),
        .mem_addr              (mem_addr),
        .old_weight            (old_weight),
        .delta_weight          (delta_weight),
        .upd_req               (upd_req),
        .upd_a                 (upd_a),
        .upd_b                 (upd_b),
        .upd_adam              (upd_adam),
        .upd_done              (upd_done),
        .upd_result            (upd_result),
        .write_en              (write_en),
        .memory_updated_weight (memory_updated_weight),
        .eta                   (eta),
        .best_error            (best_error),
        .busy                  (busy),
        .epoch_done            (epoch_done),
        .training_done         (training_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] wmem [N];
    logic [W-1:0] dmem [N];
    logic         fp_enable = 1'b1;
    int           fp_cnt = 0;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic adam; } req_t;
    typedef struct { logic [0:0] addr; logic [W-1:0] data; } wr_t;
    req_t exp_req [$];
    wr_t  exp_wr  [$];
    req_t cur_req;
    logic in_req = 1'b0;

    // Weight/delta memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            old_weight   <= wmem[mem_addr];
            delta_weight <= dmem[mem_addr];
        end
    end

    // FP adder: result two cycles after request, tagged as A+1.
    always @(posedge clk) begin
        upd_done <= 1'b0;
        if (upd_req && !upd_done && fp_enable) begin
            if (fp_cnt == 1) begin
                upd_done   <= 1'b1;
                upd_result <= upd_a + 1;
                fp_cnt     <= 0;
            end else begin
                fp_cnt <= fp_cnt + 1;
            end
        end else begin
            fp_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (upd_req) begin
            if (!in_req) begin
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL upd_req_unexpected: got request a=%h b=%h, required none", upd_a, upd_b);
                end else begin
                    cur_req = exp_req.pop_front();
                end
                in_req = 1'b1;
            end
            checks++;
            if (upd_a !== cur_req.a || upd_b !== cur_req.b || upd_adam !== cur_req.adam) begin
                errors++;
                $display("FAIL upd_operands: got a=%h b=%h adam=%b, required a=%h b=%h adam=%b",
                         upd_a, upd_b, upd_adam, cur_req.a, cur_req.b, cur_req.adam);
            end
        end else begin
            in_req = 1'b0;
        end
        if (write_en) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_addr, memory_updated_weight);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                if (mem_addr !== w.addr || memory_updated_weight !== w.data) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, memory_updated_weight, w.addr, w.data);
                end
            end
        end
    end

    // Expected FP requests and writes for one sweep, given post-EVAL eta.
    task automatic push_epoch(input logic mode, input logic [W-1:0] eta_exp);
        for (int i = 0; i < N; i++) begin
            req_t r;
            wr_t  w;
            w.addr = i[0:0];
            if (dmem[i][W-1:W-2] == 2'b00) begin
                w.data = wmem[i];
            end else begin
                r.a    = wmem[i];
                r.b    = mode ? {2'b01, ~dmem[i][31], eta_exp[30:0]}
                              : {dmem[i][33:32], ~dmem[i][31], dmem[i][30:0]};
                r.adam = ~mode;
                exp_req.push_back(r);
                w.data = wmem[i] + 1;
            end
            exp_wr.push_back(w);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; training_mode = 1'b0; squared_error = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input logic mode, input logic [W-1:0] err);
        @(posedge clk);
        #1 start = 1'b1; training_mode = mode; squared_error = err;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one sweep; checks eta/best after EVAL and the end-of-epoch flags.
    task automatic run_epoch(input string name, input logic mode, input logic [W-1:0] err,
                             input logic [W-1:0] eta_exp, input logic [W-1:0] best_exp);
        bit seen;
        push_epoch(mode, eta_exp);
        pulse_start(mode, err);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (eta !== eta_exp || best_error !== best_exp || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_eval: got eta=%h best=%h busy=%b, required eta=%h best=%h busy=1",
                     name, eta, best_error, busy, eta_exp, best_exp);
        end
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (epoch_done) seen = 1'b1;
        end
        checks++;
        if (!seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_epoch_done: got seen=%b busy=%b, required seen=1 busy=0", name, seen, busy);
        end
        checks++;
        if (exp_req.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got %0d reqs %0d writes pending, required 0 0",
                     name, exp_req.size(), exp_wr.size());
        end
        @(negedge clk);
        checks++;
        if (epoch_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse_width: got epoch_done=%b, required 0", name, epoch_done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({mem_rd_en, upd_req, write_en, busy, epoch_done, training_done} !== 6'b0 || mem_addr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got flags=%b addr=%0d, required 000000 0",
                     {mem_rd_en, upd_req, write_en, busy, epoch_done, training_done}, mem_addr);
        end
        checks++;
        if (upd_a !== '0 || upd_b !== '0 || memory_updated_weight !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h wd=%h, required zeros", upd_a, upd_b, memory_updated_weight);
        end
        checks++;
        if (eta !== c_ETA_123 || best_error !== c_BEST_RST) begin
            errors++;
            $display("FAIL reset_regs: got eta=%h best=%h, required %h %h", eta, best_error, c_ETA_123, c_BEST_RST);
        end
    endtask

    task automatic test_manhattan_improve();
        wmem[0] = c_HALF; wmem[1] = c_ONE;
        dmem[0] = c_DNEG; dmem[1] = c_DPOS;
        run_epoch("manh_improve", 1'b1, c_ONE, c_ETA_124, c_ONE);
    endtask

    task automatic test_manhattan_equal();
        run_epoch("manh_equal", 1'b1, c_ONE, c_ETA_123, c_ONE);
    endtask

    task automatic test_adam_zero_delta();
        dmem[0] = c_DPOS; dmem[1] = c_ZERO;
        run_epoch("adam_zdelta", 1'b0, c_HALF, c_ETA_123, c_HALF);
    endtask

    task automatic test_max_epochs();
        int rd;
        rd = 0;
        pulse_start(1'b1, {2'b01, 32'h3E800000});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_rd_en || busy) rd++;
        end
        checks++;
        if (training_done !== 1'b1 || rd != 0 || best_error !== c_HALF) begin
            errors++;
            $display("FAIL max_epochs: got done=%b rd=%0d best=%h, required done=1 rd=0 best=%h",
                     training_done, rd, best_error, c_HALF);
        end
        pulse_start(1'b1, c_ONE);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_rd_en || busy) rd++;
        end
        checks++;
        if (training_done !== 1'b1 || rd != 0) begin
            errors++;
            $display("FAIL start_when_done: got done=%b rd=%0d, required done=1 rd=0", training_done, rd);
        end
    endtask

    task automatic test_eta_saturation();
        do_reset();
        dmem[0] = c_DNEG; dmem[1] = c_DPOS;
        run_epoch("sat_adam", 1'b0, c_ONE, c_ETA_123, c_ONE);
        run_epoch("sat_min", 1'b1, c_TWO, c_ETA_123, c_ONE);
        run_epoch("sat_up", 1'b1, c_HALF, c_ETA_124, c_HALF);
    endtask

    task automatic test_zero_error();
        int rd;
        do_reset();
        rd = 0;
        pulse_start(1'b1, c_ZERO);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_rd_en) rd++;
        end
        checks++;
        if (training_done !== 1'b1 || rd != 0 || best_error !== c_BEST_RST) begin
            errors++;
            $display("FAIL zero_error: got done=%b rd=%0d best=%h, required done=1 rd=0 best=%h",
                     training_done, rd, best_error, c_BEST_RST);
        end
    endtask

    task automatic test_reset_mid_req();
        bit seen;
        int wr;
        req_t r;
        do_reset();
        fp_enable = 1'b0;
        wmem[0] = c_HALF; dmem[0] = c_DNEG;
        r.a = c_HALF; r.b = {2'b01, 1'b0, c_ETA_124[30:0]}; r.adam = 1'b0;
        exp_req.push_back(r);
        pulse_start(1'b1, c_ONE);
        seen = 1'b0;
        wr = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (upd_req) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_req_reach: got upd_req never, required upd_req=1");
        end
        repeat (3) begin
            @(negedge clk);
            if (write_en) wr++;
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (write_en) wr++;
        end
        checks++;
        if (wr != 0 || {mem_rd_en, upd_req, busy, epoch_done, training_done} !== 5'b0 || mem_addr !== 1'b0) begin
            errors++;
            $display("FAIL mid_req_reset: got writes=%0d flags=%b addr=%0d, required 0 00000 0",
                     wr, {mem_rd_en, upd_req, busy, epoch_done, training_done}, mem_addr);
        end
        checks++;
        if (upd_a !== '0 || upd_b !== '0 || memory_updated_weight !== '0 ||
            eta !== c_ETA_123 || best_error !== c_BEST_RST) begin
            errors++;
            $display("FAIL mid_req_regs: got a=%h b=%h wd=%h eta=%h best=%h, required zeros %h %h",
                     upd_a, upd_b, memory_updated_weight, eta, best_error, c_ETA_123, c_BEST_RST);
        end
        fp_enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_manhattan_improve();
        test_manhattan_equal();
        test_adam_zero_delta();
        test_max_epochs();
        test_eta_saturation();
        test_zero_error();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/training_sequencer.md
Name: training_sequencer

Overview:
- Parametrised weight-update sequencer for the NN training path; the next generation of the single-weight training block.
- Once per epoch it:
  - takes the squared error and tracks the best error;
  - adapts the Manhattan learning rate eta;
  - sweeps all NUMBER_WEIGHTS*NUMBER_NEURONS weights, reading the old weight and delta, and issuing each update to an external FP add unit over a req/done handshake;
  - writes the result back to weight memory.
- Supports Manhattan (training_mode=1) and Adam (training_mode=0). Sits between the error/gradient stage and the weight memory.

Parameters:
- BIT_WIDTH, 32, IEEE-754 single width.
- EXTRA_BIT, 2, exception prefix (01 normal, 00 zero).
- NUMBER_WEIGHTS, 2, weights per neuron.
- NUMBER_NEURONS, 1, neuron count.
- MAX_EPOCHS, 1024, epoch limit before forced done.
- ETA_INIT, {2'b01,32'h3DCCCCCD}, initial eta (0.1).
- ETA_MIN_EXP, 8'd100, eta exponent floor.
- ETA_MAX_EXP, 8'd126, eta exponent ceiling.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  epoch start pulse; squared_error valid this cycle.
- training_mode  in  1  1=Manhattan, 0=Adam; sampled at start.
- squared_error  in  W (W=BIT_WIDTH+EXTRA_BIT)  epoch error, always non-negative.
- mem_rd_en  out  1  weight/delta read strobe.
- mem_addr  out  clog2(N) (N=NUMBER_WEIGHTS*NUMBER_NEURONS, min 1)  read/write address.
- old_weight  in  W  weight at mem_addr, one cycle after mem_rd_en.
- delta_weight  in  W  delta at mem_addr, same timing as old_weight.
- upd_req  out  1  update request to FP unit.
- upd_a  out  W  operand A (old weight).
- upd_b  out  W  operand B (signed step).
- upd_adam  out  1  Adam-mode flag to FP unit.
- upd_done  in  1  result valid.
- upd_result  in  W  A+B (Adam: scaled).
- write_en  out  1  one-cycle write strobe.
- memory_updated_weight  out  W  write data.
- eta  out  W  current learning rate.
- best_error  out  W  lowest error seen.
- busy  out  1  sweep in progress.
- epoch_done  out  1  one-cycle pulse at sweep end.
- training_done  out  1  sticky done.

Behaviour:
- All state registered on posedge clk.
- Reset values:
  - Outputs: mem_rd_en, upd_req, write_en, busy, epoch_done, training_done = 0; mem_addr = 0; upd_a, upd_b, memory_updated_weight = 0.
  - eta = ETA_INIT; best_error = {2'b01,32'h7F7FFFFF}; epoch counter = 0.
  - rst mid-sweep aborts immediately and asserts no write.
- FSM states IDLE, EVAL, RD, WAIT_RD, REQ, WR.
- IDLE:
  - start ignored while training_done=1; start while busy is ignored.
  - Otherwise start latches the error and mode, then -> EVAL.
- EVAL (1 cycle):
  - Error comparison is an unsigned compare of bits [33:0]; exception 00 counts as zero.
  - If error is zero, or epoch count == MAX_EPOCHS-1: training_done<=1 -> IDLE, no sweep.
  - If error < best_error: best_error<=error. If Manhattan, eta exponent +1, saturating at ETA_MAX_EXP.
  - Else, if Manhattan: eta exponent -1, saturating at ETA_MIN_EXP. Equal error counts as not improved.
  - Adam: eta unchanged.
  - Then mem_addr<=0, busy<=1 -> RD.
- RD: mem_rd_en=1 for one cycle -> WAIT_RD.
- WAIT_RD: sample old_weight and delta_weight.
  - Delta exception 00 (zero): memory_updated_weight<=old_weight -> WR, skipping the adder.
  - Otherwise -> REQ.
- REQ:
  - upd_a=old_weight.
  - Manhattan: upd_b={2'b01, ~delta[31], eta[30:0]}.
  - Adam: upd_b={delta[33:32], ~delta[31], delta[30:0]}.
  - upd_adam=~mode.
  - upd_req and operands are held stable until upd_done. upd_done is accepted the same cycle or later; upd_done while upd_req=0 is ignored.
  - On upd_done: capture upd_result -> WR.
- WR:
  - write_en=1 for one cycle at the current mem_addr.
  - If mem_addr==N-1: busy<=0, epoch_done pulse, epoch count+1 -> IDLE.
  - Else mem_addr+1 -> RD.
- Latency per weight: 3 cycles plus FP unit latency; zero-delta weight takes 3 cycles.
- training_done is cleared only by rst.

Test Plan:
- Reset then start, Manhattan, error={01,3F800000}, N=2, deltas -0.09/0.09, FP unit done after 2 cycles -> best_error=1.0; eta exponent 123->124 (0x3E4CCCCD); upd_b signs +,-; write_en at addr 0 then 1; epoch_done pulse, busy low.
- Second epoch, error=1.0 again -> not improved; eta back to 0x3DCCCCCD; best_error unchanged.
- Adam epoch, delta=0.09 (3DB851EC) -> upd_adam=1; upd_b=BDB851EC; eta unchanged.
- Delta exception 00 at addr 1 -> no upd_req; write_en writes old_weight unchanged.
- Repeated non-improving errors -> eta exponent saturates at ETA_MIN_EXP; MAX_EPOCHS=4 gives training_done after the 4th start, with no sweep.
- start with error=0 -> training_done=1, no mem_rd_en. rst asserted mid-REQ -> all outputs return to reset values, with no write_en.
